multi_cycle_processor: RTL and testbench
========================================

# multi_cycle_processor

Multi-cycle successor to the single-cycle MIPS-subset core. It executes one instruction over 3–5 clock states, sharing one ALU and one unified instruction/data memory port. The memory port uses a req/ready handshake, so memories with wait states are supported. The block also adds synchronous reset, an illegal-opcode halt mode and a retired-instruction counter, and is the top-level core that the system memory model attaches to.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, byte address fetched first after reset.
- `RETIRE_W`, 32, width of the retired-instruction counter.
- `HALT_ON_ILLEGAL`, 1:
  - 1: an unknown opcode or funct enters HALT.
  - 0: it retires as a NOP.

Ports:
- `clock`  in  1  single clock; everything is sampled on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `mem_req`  out  1  memory access request; held until accepted.
- `mem_we`  out  1  1 = write (sw), 0 = read (fetch or lw).
- `mem_addr`  out  32  byte address; stable while `mem_req` is high.
- `mem_wdata`  out  32  store data; valid when `mem_we` is high.
- `mem_rdata`  in  32  read data; valid in the cycle `mem_ready` is high.
- `mem_ready`  in  1  access completes at the edge where `mem_req && mem_ready`.
- `halt`  out  1  core is stopped in HALT.
- `pc`  out  32  current PC.
- `retired`  out  `RETIRE_W`  count of completed instructions.

## Operation
- ISA:
  - R-type (opcode 0x00), funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02.
- Register file: 32×32. Register $0 reads 0 and ignores writes. Writes happen at the edge that leaves WB. Reads are combinational from IR fields.
- States and transitions:
  - FETCH: `mem_req`=1, `mem_we`=0, `mem_addr`=PC. On accept: IR←`mem_rdata`, PC←PC+4, go to DECODE.
  - DECODE: A←rs, B←rt, compute branch target PC+(sext(imm)<<2), decode the opcode.
    - j: PC←{PC[31:28], imm26, 2'b00}, retire, go to FETCH.
    - Illegal with `HALT_ON_ILLEGAL`=1: go to HALT without retiring.
    - Illegal with `HALT_ON_ILLEGAL`=0: retire, go to FETCH.
    - All other opcodes: go to EXEC.
  - EXEC: ALU computes on A and B/sext(imm).
    - beq/bne: if taken, PC←target; retire; go to FETCH.
    - lw/sw: ALUOut←A+sext(imm), go to MEM.
    - R-type/addi: go to WB.
  - MEM: `mem_req`=1, `mem_addr`=ALUOut, `mem_we`=(sw), `mem_wdata`=B.
    - sw: on accept, retire, go to FETCH.
    - lw: on accept, MDR←`mem_rdata`, go to WB.
  - WB: write the destination register, retire, go to FETCH.
    - R-type writes rd←ALUOut; addi writes rt←ALUOut; lw writes rt←MDR.
  - HALT: `mem_req`=0 and `halt`=1. The only exit is `reset`.
- Arithmetic is 32-bit wrapping with no overflow trap. slt is a signed compare and writes 1 or 0.
- `retired` increments by 1 per retire and wraps from all-ones to 0.
- Memory addresses are issued unmodified; alignment is the memory's responsibility.

## Timing
- Reset values, applied at the edge where `reset`=1:
  - state=FETCH, PC=`RESET_PC`, `retired`=0, `halt`=0, all 32 registers=0.
  - IR, A, B, ALUOut and MDR are cleared to 0.
- Outputs are decoded from registered state. `mem_req`=1 in the first cycle after `reset` deasserts.
- Reset asserted mid-instruction or during a pending memory request aborts it. No register-file write, no memory write and no retire occur at that edge. `mem_req` is 0 in the cycle after reset is sampled.
- Latency with zero wait states (`mem_ready` tied high): j 2 cycles; beq/bne 3; R-type, addi and sw 4; lw 5. Each cycle with `mem_req`=1 and `mem_ready`=0 adds one cycle, and all state holds.
- `mem_ready` while `mem_req`=0 is ignored.
- A register written in WB is visible to the next instruction's DECODE; no bypass is needed.

## Structure
- Shared package `mc_pkg`:
  - opcode and funct constants;
  - state enum (FETCH, DECODE, EXEC, MEM, WB, HALT);
  - ALU operation enum (ADD, SUB, AND, OR, SLT).
- Sub-module `mc_register_file`: 2 read ports, 1 write port, synchronous reset, $0 hardwired.
- The FSM, ALU and PC logic stay in the top module.

## Test plan
- Reset then `addi $1,$0,5`; `addi $2,$0,-3`; `add $3,$1,$2`; `slt $4,$2,$1`, ready tied high → $3=2, $4=1, `retired`=4 after 16 cycles.
- `sw $1,8($0)` then `lw $5,8($0)` with 2 wait states per access → write at address 8 of data 5, $5=5, lw takes 9 cycles, and `mem_addr` stays stable throughout each wait.
- `beq $1,$1,+2` at 0x0 → next fetch at 0xC. `bne $1,$1,+2` → next fetch at 0x4. Each takes 3 cycles.
- `j 0x40` at 0x10 → next fetch at 0x100 after 2 cycles; `retired` increments by 1.
- Opcode 0x3F:
  - `HALT_ON_ILLEGAL`=1 → `halt`=1, `mem_req`=0 forever, `retired` unchanged.
  - `HALT_ON_ILLEGAL`=0 → PC advances by 4 and `retired` increments.
- Reset asserted during a stalled sw MEM → no memory write. Next cycle `mem_req`=0, then a fetch at `RESET_PC` with `retired`=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: opcode/funct
// encodings, FSM state and ALU operation enums, and small decode/ALU helpers.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [2:0] {ADD, SUB, AND, OR, SLT} alu_op_t;

  // True for every opcode/funct pair the core knows how to execute.
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    case (op)
      OP_RTYPE: ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                     (fn == FN_OR)  || (fn == FN_SLT);
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Single shared ALU; wrapping arithmetic, signed set-less-than.
  function automatic logic [31:0] alu_compute(input alu_op_t op, input logic [31:0] a,
                                              input logic [31:0] b);
    logic [31:0] y;
    case (op)
      SUB:     y = a - b;
      AND:     y = a & b;
      OR:      y = a | b;
      SLT:     y = {31'b0, ($signed(a) < $signed(b))};
      default: y = a + b;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/mc_register_file.sv
// 32x32 register file: two combinational read ports, one write port,
// synchronous clear, register $0 always reads zero.
module mc_register_file
  import mc_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs_reg [32];

  // Clear all entries on reset; writes to $0 are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs_reg[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs_reg[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs_reg[raddr_b];

endmodule

// File: rtl/multi_cycle_processor.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB FSM around one ALU
// and one req/ready memory port, with illegal-opcode halt and retire counter.
module multi_cycle_processor
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          RETIRE_W        = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_ready,
  output logic                halt,
  output logic [31:0]         pc,
  output logic [RETIRE_W-1:0] retired
);

  state_t              state_reg, state_next;
  logic [31:0]         pc_reg, pc_next;
  logic [31:0]         ir_reg, ir_next;
  logic [31:0]         a_reg, a_next;
  logic [31:0]         b_reg, b_next;
  logic [31:0]         aluout_reg, aluout_next;
  logic [31:0]         mdr_reg, mdr_next;
  logic [RETIRE_W-1:0] retired_reg, retired_next;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] imm26;
  logic [31:0] sext_imm;
  logic [31:0] rs_data, rt_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  alu_op_t     alu_op;
  logic [31:0] alu_b, alu_y;
  logic        retire, accept;

  assign opcode   = ir_reg[31:26];
  assign rs       = ir_reg[25:21];
  assign rt       = ir_reg[20:16];
  assign rd       = ir_reg[15:11];
  assign funct    = ir_reg[5:0];
  assign imm      = ir_reg[15:0];
  assign imm26    = ir_reg[25:0];
  assign sext_imm = {{16{imm[15]}}, imm};

  // The request is masked while reset is high so an aborted access can never
  // complete (and write memory) at the reset edge.
  assign mem_req   = ((state_reg == FETCH) || (state_reg == MEM)) && !reset;
  assign mem_we    = (state_reg == MEM) && (opcode == OP_SW);
  assign mem_addr  = (state_reg == MEM) ? aluout_reg : pc_reg;
  assign mem_wdata = b_reg;
  assign accept    = mem_req && mem_ready;
  assign halt      = (state_reg == HALT);
  assign pc        = pc_reg;
  assign retired   = retired_reg;

  assign rf_we    = (state_reg == WB);
  assign rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
  assign rf_wdata = (opcode == OP_LW) ? mdr_reg : aluout_reg;

  mc_register_file u_rf (
    .clock   (clock),
    .reset   (reset),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rs_data),
    .rdata_b (rt_data),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  // ALU control: funct selects the op for R-type, branches compare via SUB.
  always_comb begin
    alu_op = ADD;
    alu_b  = sext_imm;
    case (opcode)
      OP_RTYPE: begin
        alu_b = b_reg;
        case (funct)
          FN_SUB:  alu_op = SUB;
          FN_AND:  alu_op = AND;
          FN_OR:   alu_op = OR;
          FN_SLT:  alu_op = SLT;
          default: alu_op = ADD;
        endcase
      end
      OP_BEQ, OP_BNE: begin
        alu_b  = b_reg;
        alu_op = SUB;
      end
      default: ;
    endcase
    alu_y = alu_compute(alu_op, a_reg, alu_b);
  end

  // Next-state and datapath register updates for each FSM state.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    aluout_next  = aluout_reg;
    mdr_next     = mdr_reg;
    retire       = 1'b0;
    case (state_reg)
      FETCH: begin
        if (accept) begin
          ir_next    = mem_rdata;
          pc_next    = pc_reg + 32'd4;
          state_next = DECODE;
        end
      end
      DECODE: begin
        a_next      = rs_data;
        b_next      = rt_data;
        // Branch target parked in ALUOut; pc_reg already holds PC+4.
        aluout_next = pc_reg + {sext_imm[29:0], 2'b00};
        if (!is_legal(opcode, funct)) begin
          if (HALT_ON_ILLEGAL) begin
            state_next = HALT;
          end else begin
            retire     = 1'b1;
            state_next = FETCH;
          end
        end else if (opcode == OP_J) begin
          pc_next    = {pc_reg[31:28], imm26, 2'b00};
          retire     = 1'b1;
          state_next = FETCH;
        end else begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        case (opcode)
          OP_BEQ, OP_BNE: begin
            if ((alu_y == 32'd0) == (opcode == OP_BEQ)) begin
              pc_next = aluout_reg;
            end
            retire     = 1'b1;
            state_next = FETCH;
          end
          OP_LW, OP_SW: begin
            aluout_next = alu_y;
            state_next  = MEM;
          end
          default: begin
            aluout_next = alu_y;
            state_next  = WB;
          end
        endcase
      end
      MEM: begin
        if (accept) begin
          if (opcode == OP_SW) begin
            retire     = 1'b1;
            state_next = FETCH;
          end else begin
            mdr_next   = mem_rdata;
            state_next = WB;
          end
        end
      end
      WB: begin
        retire     = 1'b1;
        state_next = FETCH;
      end
      HALT: state_next = HALT;
      default: state_next = FETCH;
    endcase
    retired_next = retire ? (retired_reg + RETIRE_W'(1)) : retired_reg;
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= FETCH;
      pc_reg      <= RESET_PC;
      ir_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      aluout_reg  <= '0;
      mdr_reg     <= '0;
      retired_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      aluout_reg  <= aluout_next;
      mdr_reg     <= mdr_next;
      retired_reg <= retired_next;
    end
  end

endmodule

// File: tb/tb_multi_cycle_processor.sv
// Directed bench for multi_cycle_processor: unified memory model with
// programmable wait states, plus a second core built to retire illegals as NOPs.
module tb_multi_cycle_processor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready, halt;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, retired;

  logic        mem_req2, mem_we2, halt2;
  logic [31:0] mem_addr2, mem_wdata2, pc2, retired2;

  logic [31:0] mem [256];
  int          wait_states = 0;
  int          wait_cnt = 0;
  logic        stall = 1'b0;
  logic        load_we = 1'b0;
  logic [7:0]  load_idx = '0;
  logic [31:0] load_data = '0;
  logic [31:0] wr_count = '0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [31:0] wr_base;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  multi_cycle_processor #(.RESET_PC(32'h0), .RETIRE_W(32), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .halt(halt), .pc(pc), .retired(retired)
  );

  multi_cycle_processor #(.RESET_PC(32'h0), .RETIRE_W(32), .HALT_ON_ILLEGAL(1'b0)) dut_nop (
    .clock(clock), .reset(reset), .mem_req(mem_req2), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(32'hFC00_0000),
    .mem_ready(1'b1), .halt(halt2), .pc(pc2), .retired(retired2)
  );

  assign mem_ready = !stall && (wait_cnt >= wait_states);
  assign mem_rdata = mem[mem_addr[9:2]];

  // Memory model: bench loads, DUT accesses after wait states, write log.
  always @(posedge clock) begin
    if (load_we) mem[load_idx] <= load_data;
    if (mem_req && mem_ready) begin
      wait_cnt <= 0;
      if (mem_we) begin
        mem[mem_addr[9:2]] <= mem_wdata;
        wr_count <= wr_count + 1;
        wr_addr  <= mem_addr;
        wr_data  <= mem_wdata;
      end
    end else if (mem_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
    pend      <= mem_req && !mem_ready;
    pend_addr <= mem_addr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end else begin
      $display("  ok %s = %h", tag, got);
    end
  endtask

  // A stalled request must keep its address until accepted.
  always @(negedge clock) begin
    if (mem_req && pend) check("addr_stable", mem_addr, pend_addr);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    load_idx  = addr[9:2];
    load_data = data;
    load_we   = 1'b1;
    @(negedge clock);
    load_we   = 1'b0;
  endtask

  task automatic begin_test(input int ws);
    reset       = 1'b1;
    stall       = 1'b0;
    wait_states = ws;
    step(2);
  endtask

  task automatic release_reset();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    @(negedge clock);

    // ALU ops, zero wait states, then store results and halt on opcode 0x3F.
    begin_test(0);
    load(32'h00, 32'h2001_0005);  // addi $1,$0,5
    load(32'h04, 32'h2002_FFFD);  // addi $2,$0,-3
    load(32'h08, 32'h0022_1820);  // add  $3,$1,$2
    load(32'h0C, 32'h0041_202A);  // slt  $4,$2,$1
    load(32'h10, 32'h0022_3022);  // sub  $6,$1,$2
    load(32'h14, 32'h0022_3824);  // and  $7,$1,$2
    load(32'h18, 32'h0022_4025);  // or   $8,$1,$2
    load(32'h1C, 32'h0022_482A);  // slt  $9,$1,$2
    load(32'h20, 32'hAC03_0080);  // sw $3,0x80($0)
    load(32'h24, 32'hAC04_0084);
    load(32'h28, 32'hAC06_0088);
    load(32'h2C, 32'hAC07_008C);
    load(32'h30, 32'hAC08_0090);
    load(32'h34, 32'hAC09_0094);
    load(32'h38, 32'hFC00_0000);  // illegal
    release_reset();
    check("rst_mem_req", {31'b0, mem_req}, 32'd1);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_halt", {31'b0, halt}, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_pc", pc, 32'h0);
    step(16);
    check("alu4_retired", retired, 32'd4);
    check("alu4_pc", pc, 32'h10);
    step(40);
    check("prog_retired", retired, 32'd14);
    check("prog_pc", pc, 32'h38);
    check("add_result", mem[8'h20], 32'd2);
    check("slt_true", mem[8'h21], 32'd1);
    check("sub_result", mem[8'h22], 32'd8);
    check("and_result", mem[8'h23], 32'd5);
    check("or_result", mem[8'h24], 32'hFFFF_FFFD);
    check("slt_false", mem[8'h25], 32'd0);
    step(2);
    check("ill_halt", {31'b0, halt}, 32'd1);
    check("ill_req", {31'b0, mem_req}, 32'd0);
    check("ill_retired", retired, 32'd14);
    step(5);
    check("halt_hold", {31'b0, halt}, 32'd1);
    check("halt_req", {31'b0, mem_req}, 32'd0);
    check("halt_pc", pc, 32'h3C);
    check("halt_retired", retired, 32'd14);

    // sw/lw with two wait states per access.
    begin_test(2);
    load(32'h00, 32'h0800_0010);  // j 0x10 -> 0x40
    load(32'h40, 32'h2001_0005);  // addi $1,$0,5
    load(32'h44, 32'hAC01_0008);  // sw $1,8($0)
    load(32'h48, 32'h8C05_0008);  // lw $5,8($0)
    load(32'h4C, 32'hAC05_0084);  // sw $5,0x84($0)
    load(32'h50, 32'hFC00_0000);
    release_reset();
    wr_base = wr_count;
    step(4);
    check("ws_j_pc", pc, 32'h40);
    step(12);
    check("sw_wait_req", {31'b0, mem_req}, 32'd1);
    check("sw_wait_we", {31'b0, mem_we}, 32'd1);
    check("sw_wait_addr", mem_addr, 32'h8);
    check("sw_wait_wdata", mem_wdata, 32'd5);
    step(2);
    check("sw_wr_count", wr_count, wr_base + 32'd1);
    check("sw_wr_addr", wr_addr, 32'h8);
    check("sw_wr_data", wr_data, 32'd5);
    check("sw_retired", retired, 32'd3);
    step(8);
    check("lw_8cyc_retired", retired, 32'd3);
    step(1);
    check("lw_9cyc_retired", retired, 32'd4);
    step(8);
    check("lw_value", mem[8'h21], 32'd5);
    check("ws_retired", retired, 32'd5);

    // Branches and jump, zero wait states.
    begin_test(0);
    load(32'h000, 32'h1021_0002);  // beq $1,$1,+2
    load(32'h00C, 32'h1421_0002);  // bne $1,$1,+2
    load(32'h010, 32'h0800_0040);  // j 0x40 -> 0x100
    load(32'h100, 32'h2002_0001);  // addi $2,$0,1
    load(32'h104, 32'h1440_0003);  // bne $2,$0,+3 -> 0x114
    load(32'h114, 32'h1040_0005);  // beq $2,$0,+5 not taken
    load(32'h118, 32'hFC00_0000);
    release_reset();
    step(2);
    check("beq_2cyc_pc", pc, 32'h4);
    step(1);
    check("beq_taken_pc", pc, 32'hC);
    check("beq_fetch_addr", mem_addr, 32'hC);
    check("beq_retired", retired, 32'd1);
    step(3);
    check("bne_nt_pc", pc, 32'h10);
    step(2);
    check("j_pc", pc, 32'h100);
    check("j_fetch_addr", mem_addr, 32'h100);
    check("j_retired", retired, 32'd3);
    step(7);
    check("bne_taken_pc", pc, 32'h114);
    step(3);
    check("beq_nt_pc", pc, 32'h118);
    check("br_retired", retired, 32'd6);

    // Illegal opcodes retire as NOPs on the second core.
    begin_test(0);
    release_reset();
    step(2);
    check("nop_pc", pc2, 32'h4);
    check("nop_retired", retired2, 32'd1);
    step(4);
    check("nop_pc3", pc2, 32'hC);
    check("nop_retired3", retired2, 32'd3);
    check("nop_halt", {31'b0, halt2}, 32'd0);
    check("nop_fetch_addr", mem_addr2, 32'hC);
    check("nop_req", {30'b0, mem_req2, mem_we2}, 32'd2);

    // Reset during a stalled sw: no write, request drops, refetch at RESET_PC.
    begin_test(0);
    load(32'h00, 32'h2001_0007);  // addi $1,$0,7
    load(32'h04, 32'hAC01_0080);  // sw $1,0x80($0)
    release_reset();
    step(7);
    check("stall_sw_req", {30'b0, mem_req, mem_we}, 32'd3);
    check("stall_sw_addr", mem_addr, 32'h80);
    check("stall_retired", retired, 32'd1);
    stall   = 1'b1;
    wr_base = wr_count;
    step(2);
    check("stall_hold_req", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    stall = 1'b0;
    step(1);
    check("abort_req", {31'b0, mem_req}, 32'd0);
    check("abort_no_write", wr_count, wr_base);
    check("abort_retired", retired, 32'd0);
    check("abort_pc", pc, 32'h0);
    release_reset();
    check("refetch_req", {30'b0, mem_req, mem_we}, 32'd2);
    check("refetch_addr", mem_addr, 32'h0);
    step(4);
    check("refetch_retired", retired, 32'd1);
    check("abort_no_write2", wr_count, wr_base);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
